// File: rtl/sound_pkg.sv
// Shared definitions for the sound record/playback engine: state encoding and
// the address-width helper used by the engine and its word memory.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } state_t;

    // Address width for a memory of the given depth (ADDR_W = $clog2(DEPTH)).
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sound_mem.sv
// Single-port WORD_W x DEPTH sample memory with write enable and a registered
// (read-first) read port; written so synthesis maps it onto block RAM.
module sound_mem
    import sound_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sound_engine.sv
// PDM microphone record / 1-bit audio playback engine with internal word memory.
// Define LOOP_PLAYBACK_EN to let loop_mode repeat the recording without a gap.
module sound_engine
    import sound_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int CLK_DIV = 20,
    parameter int MIC_LR  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   record_req,
    input  logic                   play_req,
    input  logic                   loop_mode,
    input  logic                   mic_data,
    output logic                   mic_clk,
    output logic                   mic_lrsel,
    output logic                   aud_pwm,
    output logic                   aud_en,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] rec_len
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(WORD_W + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  REC_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(WORD_W);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                mic_clk_q, mic_clk_d;
    logic                rec_prev_q, play_prev_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic [WORD_W-2:0]   rec_sh_q, rec_sh_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [BIT_W-1:0]    pbit_q, pbit_d;
    logic [WORD_W-1:0]   play_sh_q, play_sh_d;
    logic                aud_pwm_q, aud_pwm_d;
    logic                last_q, last_d;
    logic                loop_q, loop_d;

    logic                div_wrap, bit_tick;
    logic                rec_edge, play_edge;
    logic                loop_en;
    logic [ADDR_W-1:0]   rec_last;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata, mem_rdata;

`ifdef LOOP_PLAYBACK_EN
    assign loop_en = loop_mode;
`else
    logic unused_loop_mode;
    assign unused_loop_mode = loop_mode;
    assign loop_en          = 1'b0;
`endif

    assign div_wrap  = (div_q == DIV_LAST);
    // Only the wrap that raises mic_clk is a bit tick.
    assign bit_tick  = div_wrap & ~mic_clk_q;
    assign rec_edge  = record_req & ~rec_prev_q;
    assign play_edge = play_req & ~play_prev_q;
    // Index of the final recorded word; wraps correctly when rec_len == DEPTH.
    assign rec_last  = rec_len_q[ADDR_W-1:0] - ADDR_W'(1);
    assign mem_wdata = {rec_sh_q, mic_data};

    always_comb begin
        state_d   = state_q;
        div_d     = div_wrap ? '0 : div_q + DIV_W'(1);
        mic_clk_d = mic_clk_q ^ div_wrap;
        wr_addr_d = wr_addr_q;
        bit_cnt_d = bit_cnt_q;
        rec_len_d = rec_len_q;
        rec_sh_d  = rec_sh_q;
        rd_addr_d = rd_addr_q;
        pbit_d    = pbit_q;
        play_sh_d = play_sh_q;
        aud_pwm_d = aud_pwm_q;
        last_d    = last_q;
        loop_d    = loop_q;
        mem_we    = 1'b0;
        mem_addr  = rd_addr_q;

        unique case (state_q)
            IDLE: begin
                aud_pwm_d = 1'b0;
                if (rec_edge) begin
                    state_d   = REC;
                    wr_addr_d = '0;
                    bit_cnt_d = '0;
                    rec_len_d = '0;
                end else if (play_edge && (rec_len_q != '0)) begin
                    state_d   = PLAY;
                    rd_addr_d = '0;
                    pbit_d    = BIT_FULL;
                    last_d    = 1'b0;
                    loop_d    = 1'b0;
                end
                mem_addr = rd_addr_d;
            end

            REC: begin
                mem_addr = wr_addr_q;
                if (rec_edge) begin
                    state_d = IDLE;
                end else if (bit_tick) begin
                    rec_sh_d = (WORD_W-1)'({rec_sh_q, mic_data});
                    if (bit_cnt_q == REC_LAST) begin
                        mem_we    = 1'b1;
                        bit_cnt_d = '0;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        rec_len_d = {1'b0, wr_addr_q} + (ADDR_W+1)'(1);
                        if (wr_addr_q == ADDR_LAST) begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            PLAY: begin
                if (play_edge) begin
                    state_d   = IDLE;
                    aud_pwm_d = 1'b0;
                end else if (bit_tick) begin
                    if (pbit_q == BIT_FULL) begin
                        if (last_q && !loop_q) begin
                            state_d   = IDLE;
                            aud_pwm_d = 1'b0;
                        end else begin
                            // Word load: prefetched word moves to the shifter and
                            // the read of the following word is issued now.
                            aud_pwm_d = mem_rdata[WORD_W-1];
                            play_sh_d = {mem_rdata[WORD_W-2:0], 1'b0};
                            pbit_d    = BIT_W'(1);
                            last_d    = (rd_addr_q == rec_last);
                            loop_d    = loop_en;
                            if (rd_addr_q == rec_last) begin
                                rd_addr_d = loop_en ? '0 : rd_addr_q;
                            end else begin
                                rd_addr_d = rd_addr_q + ADDR_W'(1);
                            end
                        end
                    end else begin
                        aud_pwm_d = play_sh_q[WORD_W-1];
                        play_sh_d = {play_sh_q[WORD_W-2:0], 1'b0};
                        pbit_d    = pbit_q + BIT_W'(1);
                    end
                end
                mem_addr = rd_addr_d;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            mic_clk_q   <= 1'b0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
            wr_addr_q   <= '0;
            bit_cnt_q   <= '0;
            rec_len_q   <= '0;
            rd_addr_q   <= '0;
            pbit_q      <= '0;
            aud_pwm_q   <= 1'b0;
            last_q      <= 1'b0;
            loop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mic_clk_q   <= mic_clk_d;
            rec_prev_q  <= record_req;
            play_prev_q <= play_req;
            wr_addr_q   <= wr_addr_d;
            bit_cnt_q   <= bit_cnt_d;
            rec_len_q   <= rec_len_d;
            rd_addr_q   <= rd_addr_d;
            pbit_q      <= pbit_d;
            aud_pwm_q   <= aud_pwm_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
        end
        rec_sh_q  <= rec_sh_d;
        play_sh_q <= play_sh_d;
    end

    sound_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign mic_clk   = mic_clk_q;
    assign mic_lrsel = 1'(MIC_LR);
    assign aud_pwm   = aud_pwm_q;
    assign aud_en    = (state_q == PLAY);
    assign state     = state_q;
    assign rec_len   = rec_len_q;

endmodule

// File: tb/tb_sound_engine.sv
// Scoreboard bench for sound_engine: recorded PDM bits feed a word-level model,
// playback pushes expected bits that a monitor pops at every mic_clk rise.
module tb_sound_engine;

    localparam int WORD_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int NB      = WORD_W * DEPTH;
    localparam int TICK    = 2 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset, record_req, play_req, loop_mode, mic_data;
    logic       mic_clk, mic_lrsel, aud_pwm, aud_en;
    logic [1:0] state;
    logic [2:0] rec_len;

    int checks = 0;
    int errors = 0;

    logic              exp_q[$];
    logic              rec_bits[$];
    logic [WORD_W-1:0] mem_m [DEPTH];
    int                len_m = 0;
    logic              mon_en = 1'b1;
    logic              exp_bit;

    always #5 clk = ~clk;

    sound_engine #(
        .WORD_W  (WORD_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV),
        .MIC_LR  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .record_req (record_req),
        .play_req   (play_req),
        .loop_mode  (loop_mode),
        .mic_data   (mic_data),
        .mic_clk    (mic_clk),
        .mic_lrsel  (mic_lrsel),
        .aud_pwm    (aud_pwm),
        .aud_en     (aud_en),
        .state      (state),
        .rec_len    (rec_len)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every mic_clk rise is a bit tick; while the amplifier is enabled
    // the DUT must present exactly the next expected bit.
    always begin
        @(posedge mic_clk);
        @(negedge clk);
        if (mon_en && aud_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got bit %b, expected no playback", aud_pwm);
            end else begin
                exp_bit = exp_q.pop_front();
                if (aud_pwm !== exp_bit) begin
                    errors++;
                    $display("FAIL stream_bit: got %b, expected %b (%0d left)", aud_pwm, exp_bit, exp_q.size());
                end
            end
        end
    end

    task automatic wait_state(input logic [1:0] want, input int max_cyc, input string name);
        int n = 0;
        while (state !== want && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(want));
    endtask

    // Wait for the next mic_clk rise, returning #1 after the clk edge that made it.
    task automatic wait_tick(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int n = 0; n < 2 * TICK + 4; n++) begin
            prev = mic_clk;
            @(posedge clk);
            #1;
            if (prev === 1'b0 && mic_clk === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no mic_clk rise, expected one within %0d cycles", 2 * TICK + 4);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        for (int b = WORD_W - 1; b >= 0; b--) rec_bits.push_back(w[b]);
    endtask

    // Records rec_bits; stops with a record edge unless the memory fills first.
    task automatic do_record(input string tag);
        int nbits = rec_bits.size();
        int nw;
        bit ok;
        @(negedge clk);
        record_req = 1'b1;
        wait_state(2'd1, 6, {tag, "_enter"});
        record_req = 1'b0;
        mic_data = rec_bits[0];
        for (int i = 1; i < nbits; i++) begin
            wait_tick(ok);
            if (!ok) break;
            mic_data = rec_bits[i];
        end
        wait_tick(ok);
        nw = nbits / WORD_W;
        if (nw > DEPTH) nw = DEPTH;
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < WORD_W; b++)
                mem_m[w][WORD_W-1-b] = rec_bits[w*WORD_W + b];
        len_m = nw;
        if (nbits < NB) begin
            @(negedge clk);
            record_req = 1'b1;
            wait_state(2'd0, 6, {tag, "_stop"});
            record_req = 1'b0;
        end else begin
            wait_state(2'd0, 2, {tag, "_autostop"});
        end
        check({tag, "_rec_len"}, 32'(rec_len), 32'(len_m));
        rec_bits.delete();
    endtask

    task automatic push_expected(input int reps);
        for (int r = 0; r < reps; r++)
            for (int w = 0; w < len_m; w++)
                for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(mem_m[w][b]);
    endtask

    // Plays until all pushed bits are consumed; a record edge mid-play must be ignored.
    task automatic drain(input int reps, input string tag);
        int n = 0;
        int bound = reps * len_m * WORD_W * TICK + 40;
        push_expected(reps);
        @(negedge clk);
        play_req = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
            if (n == 2)  play_req = 1'b0;
            if (n == 12) record_req = 1'b1;
            if (n == 15) record_req = 1'b0;
        end
        play_req   = 1'b0;
        record_req = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_play(input string tag);
        drain(1, tag);
        wait_state(2'd0, TICK + 4, {tag, "_end_state"});
        check({tag, "_end_aud_en"}, 32'(aud_en), 32'd0);
        check({tag, "_end_aud_pwm"}, 32'(aud_pwm), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises[$];
        logic prev;
        int bad;
        int nbits;

        reset = 1'b1; record_req = 1'b0; play_req = 1'b0;
        loop_mode = 1'b0; mic_data = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state",   32'(state),     32'd0);
        check("rst_aud_en",  32'(aud_en),    32'd0);
        check("rst_aud_pwm", 32'(aud_pwm),   32'd0);
        check("rst_rec_len", 32'(rec_len),   32'd0);
        check("rst_mic_clk", 32'(mic_clk),   32'd0);
        check("rst_lrsel",   32'(mic_lrsel), 32'd0);
        reset = 1'b0;

        // Idle: mic_clk period and quiescent outputs.
        bad = 0;
        prev = mic_clk;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prev === 1'b0 && mic_clk === 1'b1) rises.push_back(c);
            prev = mic_clk;
            if (state !== 2'd0 || aud_en !== 1'b0) bad++;
        end
        if (rises.size() >= 2) check("mic_clk_period", 32'(rises[1] - rises[0]), 32'(TICK));
        else check("mic_clk_rises", 32'(rises.size()), 32'd2);
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_rec_len", 32'(rec_len), 32'd0);

        // Two known words plus a 3-bit partial word that must be dropped.
        push_word(8'hA5);
        push_word(8'h3C);
        rec_bits.push_back(1'b1); rec_bits.push_back(1'b0); rec_bits.push_back(1'b1);
        do_record("pat");
        do_play("pat_play");

        // 40 ticks without stop: memory fills after 32 bits.
        for (int i = 0; i < 40; i++) rec_bits.push_back(1'($urandom));
        do_record("full");
        do_play("full_play");

        // Randomised lengths, including partial words.
        for (int r = 0; r < 3; r++) begin
            nbits = $urandom_range(WORD_W, NB - 1);
            for (int i = 0; i < nbits; i++) rec_bits.push_back(1'($urandom));
            do_record($sformatf("rnd%0d", r));
            do_play($sformatf("rnd%0d_play", r));
        end

        push_word(WORD_W'($urandom));
        push_word(WORD_W'($urandom));
        do_record("loop");
        loop_mode = 1'b1;
`ifdef LOOP_PLAYBACK_EN
        // Three back-to-back passes with no gap, then a play edge stops it.
        drain(3, "loop_run");
        play_req = 1'b1;
        wait_state(2'd0, 4, "loop_stop_state");
        play_req = 1'b0;
        check("loop_stop_aud_en", 32'(aud_en), 32'd0);
        repeat (3 * TICK) @(negedge clk);
        check("loop_stays_idle", 32'(state), 32'd0);
`else
        do_play("loop_ignored");
`endif
        loop_mode = 1'b0;

        // Reset in the middle of playback.
        push_expected(1);
        @(negedge clk);
        play_req = 1'b1;
        repeat (2) @(negedge clk);
        play_req = 1'b0;
        wait_state(2'd2, 4, "rstplay_enter");
        repeat (5 * TICK) @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rstplay_state",   32'(state),   32'd0);
        check("rstplay_aud_en",  32'(aud_en),  32'd0);
        check("rstplay_rec_len", 32'(rec_len), 32'd0);
        check("rstplay_aud_pwm", 32'(aud_pwm), 32'd0);
        reset = 1'b0;
        len_m = 0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Simultaneous edges in IDLE choose record; immediate stop leaves nothing.
        record_req = 1'b1;
        play_req   = 1'b1;
        wait_state(2'd1, 6, "simul_rec");
        record_req = 1'b0;
        play_req   = 1'b0;
        @(negedge clk);
        record_req = 1'b1;
        wait_state(2'd0, 6, "simul_stop");
        record_req = 1'b0;
        check("simul_rec_len", 32'(rec_len), 32'd0);

        // Play request with nothing recorded is ignored.
        bad = 0;
        @(negedge clk);
        play_req = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (state !== 2'd0 || aud_en !== 1'b0) bad++;
        end
        play_req = 1'b0;
        check("empty_play_idle", 32'(bad), 32'd0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
